// File: rtl/bist_misr_ora.sv
// bist_misr_ora: output response analyser for the BIST loop.
// Compacts the CUT response stream into a MISR signature and, once the
// programmed number of patterns has been absorbed, grades it against the
// fault-free signature and reports pass/fail to the BIST controller.
module bist_misr_ora #(
  parameter int              WIDTH        = 2,
  parameter int              SIG_W        = 8,
  parameter int              NUM_PATTERNS = 8,
  parameter logic [SIG_W-1:0] POLY        = 8'h1D,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = 8'h47,
  localparam int             CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] dataIn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The sample that takes count to NUM_PATTERNS is the final one of a run.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

  state_t           state;
  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] sig_next;

  // Zero-extend the response to the signature width; written bitwise so the
  // WIDTH == SIG_W case needs no zero-length replication.
  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = dataIn;
  end

  // One MISR step: shift left, fold the outgoing MSB back through the taps,
  // then inject the new response bits.
  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0} ^ data_ext;
    if (signature[SIG_W-1]) begin
      sig_next = sig_next ^ POLY;
    end
  end

  // Control FSM with registered status outputs and the signature/count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A new run clears everything; a response arriving alongside start
          // belongs to no run and is deliberately dropped.
          if (start) begin
            state     <= COMPACT;
            signature <= '0;
            count     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
          end
        end
        COMPACT: begin
          // Stalls simply hold; dataIn is never looked at while invalid.
          if (data_valid) begin
            signature <= sig_next;
            count     <= count + 1'b1;
            if (count == LAST_IDX) begin
              state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          // Signature is frozen here, so grade it and publish the verdict.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (signature == GOLDEN_SIG);
          fail  <= (signature != GOLDEN_SIG);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
